// File: rtl/morse_text_buffer_pkg.sv
// Shared constants and types for the Morse text line buffer.
package morse_text_buffer_pkg;

    localparam int MTB_CHAR_W = 6;
    localparam int MTB_DEPTH  = 16;
    localparam int MTB_WIN    = 6;

    // Character codes: 0..35 are letters/digits, 36 is a blank, 63 marks a bad capture.
    localparam logic [MTB_CHAR_W-1:0] CHAR_CODE_SPACE = 6'd36;
    localparam logic [MTB_CHAR_W-1:0] CHAR_CODE_ERR   = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PUSH_CHAR  = 2'd1,
        ST_PUSH_SPACE = 2'd2
    } mtb_state_t;

endpackage

// File: rtl/morse_char_ring.sv
// Ring storage for recognized characters: write pointer, fill count, sticky
// overflow, and several read ports addressed by offset back from the newest entry.
module morse_char_ring
    import morse_text_buffer_pkg::*;
#(
    parameter int CHAR_W = MTB_CHAR_W,
    parameter int DEPTH  = MTB_DEPTH,
    parameter int NRD    = MTB_WIN + 1,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [CHAR_W-1:0]     wr_data,
    input  logic [NRD*AW-1:0]     rd_off,
    output logic [NRD*CHAR_W-1:0] rd_data,
    output logic [CW-1:0]         count,
    output logic                  overflow
);

    logic [CHAR_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;

    // Advance pointer and count on a write; a write into a full ring replaces the oldest entry.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_q == CW'(DEPTH)) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Control state of the ring, cleared asynchronously.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Character storage; contents beyond count are never shown, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        assign rd_data[i*CHAR_W +: CHAR_W] = mem_q[wr_ptr_q - AW'(1) - rd_off[i*AW +: AW]];
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/morse_text_buffer.sv
// Collects recognized Morse characters into a ring and presents a scrollable
// window of the most recent characters, newest in the lowest slot.
module morse_text_buffer
    import morse_text_buffer_pkg::*;
#(
    parameter int CHAR_W = MTB_CHAR_W,
    parameter int DEPTH  = MTB_DEPTH,
    parameter int WIN    = MTB_WIN
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    ce,
    input  logic [CHAR_W-1:0]       char_in,
    input  logic                    char_end,
    input  logic                    word_end,
    input  logic                    error,
    input  logic                    scroll_l,
    input  logic                    scroll_r,
    output logic [WIN*CHAR_W-1:0]   win_chars,
    output logic [$clog2(DEPTH):0]  count,
    output logic [$clog2(DEPTH)-1:0] view_off,
    output logic                    overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CHAR_W-1:0] SPACE_C = CHAR_W'(CHAR_CODE_SPACE);
    localparam logic [CHAR_W-1:0] ERR_C   = CHAR_W'(CHAR_CODE_ERR);

    mtb_state_t          state_q, state_d;
    logic [3:0]          prev_q, prev_d;
    logic                pend_char_q, pend_char_d;
    logic [CHAR_W-1:0]   pend_code_q, pend_code_d;
    logic                pend_word_q, pend_word_d;
    logic                pend_space_q, pend_space_d;
    logic [CHAR_W-1:0]   cur_code_q, cur_code_d;
    logic [AW-1:0]       view_off_q, view_off_d;
    logic [WIN*CHAR_W-1:0] win_q, win_d;

    logic                char_rise, word_rise, scl_rise, scr_rise;
    logic [CHAR_W-1:0]   new_code;
    logic                wr_req;
    logic [CHAR_W-1:0]   wr_data;
    logic [(WIN+1)*AW-1:0]     rd_off;
    logic [(WIN+1)*CHAR_W-1:0] rd_data;
    logic [CW-1:0]       count_w;
    logic                overflow_w;
    logic [CW-1:0]       scroll_lim;
    logic [WIN-1:0]      slot_vis;
    logic [CHAR_W-1:0]   newest;

    assign char_rise = char_end & ~prev_q[0];
    assign word_rise = word_end & ~prev_q[1];
    assign scl_rise  = scroll_l & ~prev_q[2];
    assign scr_rise  = scroll_r & ~prev_q[3];
    assign prev_d    = {scroll_r, scroll_l, word_end, char_end};
    assign new_code  = error ? ERR_C : char_in;

    morse_char_ring #(
        .CHAR_W (CHAR_W),
        .DEPTH  (DEPTH),
        .NRD    (WIN + 1)
    ) u_ring (
        .clk      (clk),
        .clr      (clr),
        .wr_en    (wr_req & ce),
        .wr_data  (wr_data),
        .rd_off   (rd_off),
        .rd_data  (rd_data),
        .count    (count_w),
        .overflow (overflow_w)
    );

    // Read ports 0..WIN-1 follow the window; the extra port always looks at the newest entry.
    for (genvar k = 0; k < WIN; k++) begin : g_win
        assign rd_off[k*AW +: AW] = view_off_q + AW'(k);
        assign slot_vis[k]        = (CW'(view_off_q) + CW'(k)) < count_w;
    end
    assign rd_off[WIN*AW +: AW] = '0;
    assign newest = rd_data[WIN*CHAR_W +: CHAR_W];

    assign scroll_lim = (count_w > CW'(WIN)) ? (count_w - CW'(WIN)) : '0;

    // Next-state logic: push sequencing, latching of early rises, scrolling.
    always_comb begin
        state_d      = state_q;
        pend_char_d  = pend_char_q;
        pend_code_d  = pend_code_q;
        pend_word_d  = pend_word_q;
        pend_space_d = pend_space_q;
        cur_code_d   = cur_code_q;
        view_off_d   = view_off_q;
        wr_req       = 1'b0;
        wr_data      = cur_code_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_char_q || char_rise) begin
                    state_d      = ST_PUSH_CHAR;
                    cur_code_d   = pend_char_q ? pend_code_q : new_code;
                    pend_space_d = pend_word_q | word_rise;
                    // A fresh rise arriving while an older one is serviced stays queued.
                    pend_char_d  = pend_char_q & char_rise;
                    if (pend_char_q && char_rise) begin
                        pend_code_d = new_code;
                    end
                    pend_word_d  = pend_word_q & word_rise;
                end else if (pend_word_q || word_rise) begin
                    state_d     = ST_PUSH_SPACE;
                    pend_word_d = pend_word_q & word_rise;
                end
                if (scl_rise && !scr_rise && (CW'(view_off_q) < scroll_lim)) begin
                    view_off_d = view_off_q + AW'(1);
                end else if (scr_rise && !scl_rise && (view_off_q != '0)) begin
                    view_off_d = view_off_q - AW'(1);
                end
            end
            ST_PUSH_CHAR: begin
                wr_req       = 1'b1;
                wr_data      = cur_code_q;
                view_off_d   = '0;
                pend_space_d = 1'b0;
                state_d      = pend_space_q ? ST_PUSH_SPACE : ST_IDLE;
            end
            ST_PUSH_SPACE: begin
                if ((count_w != '0) && (newest != SPACE_C)) begin
                    wr_req     = 1'b1;
                    wr_data    = SPACE_C;
                    view_off_d = '0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE) begin
            if (char_rise && !pend_char_q) begin
                pend_char_d = 1'b1;
                pend_code_d = new_code;
            end
            if (word_rise) begin
                pend_word_d = 1'b1;
            end
        end
    end

    // Window contents: stored entries where they exist, blanks past the oldest.
    always_comb begin
        win_d = '0;
        for (int k = 0; k < WIN; k++) begin
            win_d[k*CHAR_W +: CHAR_W] = slot_vis[k] ? rd_data[k*CHAR_W +: CHAR_W] : SPACE_C;
        end
    end

    // Registered FSM, edge history and window; everything holds while ce is low.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            pend_char_q  <= 1'b0;
            pend_code_q  <= '0;
            pend_word_q  <= 1'b0;
            pend_space_q <= 1'b0;
            cur_code_q   <= '0;
            view_off_q   <= '0;
            win_q        <= {WIN{SPACE_C}};
        end else if (ce) begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            pend_char_q  <= pend_char_d;
            pend_code_q  <= pend_code_d;
            pend_word_q  <= pend_word_d;
            pend_space_q <= pend_space_d;
            cur_code_q   <= cur_code_d;
            view_off_q   <= view_off_d;
            win_q        <= win_d;
        end
    end

    assign win_chars = win_q;
    assign count     = count_w;
    assign view_off  = view_off_q;
    assign overflow  = overflow_w;

endmodule
